ltl_symbol_streamer: RTL and testbench

LTL_SYMBOL_STREAMER -- requirements
Module: ltl_symbol_streamer

---
 rtl/ltl_symbol_streamer.sv | 142 ++++++++++++++
 tb/tb_ltl_symbol_streamer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ltl_symbol_streamer.sv
// ltl_symbol_streamer
//   Streams encoded proposition words from a producer into a set of automata
//   monitors. A new trace is framed by frame_start. The block holds the
//   monitors in reset for RESET_CYCLES cycles, then forwards buffered words
//   one per cycle as symbols. On frame_end it drains the FIFO and returns to
//   IDLE.
//
// Ports
//   clk           clock
//   reset         synchronous, active-high reset
//   frame_start   one-cycle request to begin a new trace (aborts any frame in progress)
//   frame_end     one-cycle request to end the trace after draining
//   prop_valid    producer offers prop_bits
//   prop_bits     8-bit encoded proposition word
//   prop_ready    word is accepted this cycle (STREAM and FIFO not full)
//   mon_reset     reset to the monitors
//   mon_run       symbol strobe to the monitors
//   mon_symbol    symbol to the monitors (holds its value while mon_run is low)
//   busy          high whenever the block is not IDLE
//   drop_count    words refused in STREAM because the FIFO was full (saturating)
//   symbol_count  symbols issued in the current frame (wrapping)
module ltl_symbol_streamer #(
  parameter int DEPTH        = 8,
  parameter int RESET_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        prop_valid,
  input  logic [7:0]  prop_bits,
  output logic        prop_ready,
  output logic        mon_reset,
  output logic        mon_run,
  output logic [7:0]  mon_symbol,
  output logic        busy,
  output logic [15:0] drop_count,
  output logic [31:0] symbol_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RESET_CYCLES) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] flush_cnt_reg;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          mon_reset_reg, mon_run_reg;
  logic [7:0]    mon_symbol_reg;
  logic [15:0]   drop_count_reg;
  logic [31:0]   symbol_count_reg;

  logic full, empty, flush, push, pop, drop;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);

  // frame_start in any non-reset cycle discards the FIFO and starts a new
  // reset window; it also suppresses the pop/push of that cycle so nothing
  // from the aborted frame reaches the monitors.
  assign flush = frame_start;
  assign prop_ready = (state_reg == ST_STREAM) && !full;
  assign push = prop_valid && prop_ready && !flush;
  assign pop  = ((state_reg == ST_STREAM) || (state_reg == ST_DRAIN)) && !empty && !flush;
  assign drop = (state_reg == ST_STREAM) && prop_valid && !prop_ready;

  always_comb begin
    state_next = state_reg;
    if (frame_start) begin
      state_next = ST_FLUSH;
    end else begin
      case (state_reg)
        ST_FLUSH:  if (flush_cnt_reg == CW'(RESET_CYCLES - 1)) state_next = ST_STREAM;
        ST_STREAM: if (frame_end) state_next = ST_DRAIN;
        // No pushes in DRAIN: with at most one entry left it is popped now,
        // so IDLE follows the last pop (or immediately when already empty).
        ST_DRAIN:  if (count_reg <= (AW+1)'(1)) state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // FIFO storage: no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= prop_bits;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      flush_cnt_reg    <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      mon_reset_reg    <= 1'b1;
      mon_run_reg      <= 1'b0;
      mon_symbol_reg   <= 8'h00;
      drop_count_reg   <= '0;
      symbol_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      mon_reset_reg <= (state_next == ST_FLUSH);
      mon_run_reg   <= pop;
      if (pop) mon_symbol_reg <= mem[rd_ptr_reg];

      if (flush || (state_reg != ST_FLUSH)) flush_cnt_reg <= '0;
      else                                  flush_cnt_reg <= flush_cnt_reg + CW'(1);

      if (flush) begin
        wr_ptr_reg       <= '0;
        rd_ptr_reg       <= '0;
        count_reg        <= '0;
        drop_count_reg   <= '0;
        symbol_count_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + (AW+1)'(1);
          2'b01:   count_reg <= count_reg - (AW+1)'(1);
          default: count_reg <= count_reg;
        endcase
        if (drop && (drop_count_reg != 16'hFFFF)) drop_count_reg <= drop_count_reg + 16'd1;
        if (mon_run_reg) symbol_count_reg <= symbol_count_reg + 32'd1;
      end
    end
  end

  assign mon_reset    = mon_reset_reg;
  assign mon_run      = mon_run_reg;
  assign mon_symbol   = mon_symbol_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign drop_count   = drop_count_reg;
  assign symbol_count = symbol_count_reg;

endmodule

// File: tb/tb_ltl_symbol_streamer.sv
// Testbench for ltl_symbol_streamer: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the framing rules.
module tb_ltl_symbol_streamer;
  localparam int DEPTH = 8;
  localparam int RC    = 2;
  localparam int M_IDLE = 0, M_FLUSH = 1, M_STREAM = 2, M_DRAIN = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1, frame_start = 1'b0, frame_end = 1'b0, prop_valid = 1'b0;
  logic [7:0]  prop_bits = 8'h00;
  logic        prop_ready, mon_reset, mon_run, busy;
  logic [7:0]  mon_symbol;
  logic [15:0] drop_count;
  logic [31:0] symbol_count;

  int total = 0;
  int bad   = 0;

  ltl_symbol_streamer #(.DEPTH(DEPTH), .RESET_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .prop_valid(prop_valid), .prop_bits(prop_bits), .prop_ready(prop_ready),
    .mon_reset(mon_reset), .mon_run(mon_run), .mon_symbol(mon_symbol), .busy(busy),
    .drop_count(drop_count), .symbol_count(symbol_count)
  );

  always #5 clk = ~clk;

  // Reference model: mode, cycles of reset left, and a queue for the FIFO.
  int          m_mode = M_IDLE;
  int          m_left = 0;
  logic [7:0]  m_q[$];
  logic        m_reset = 1'b1, m_run = 1'b0;
  logic [7:0]  m_sym = 8'h00;
  logic [15:0] m_drops = 16'd0;
  logic [31:0] m_syms = 32'd0;

  function automatic logic m_ready();
    return (m_mode == M_STREAM) && (m_q.size() < DEPTH);
  endfunction

  task automatic model_step(input logic r, input logic fs, input logic fe,
                            input logic pv, input logic [7:0] pb);
    logic rdy;
    rdy = m_ready();
    if (r) begin
      m_mode = M_IDLE; m_q.delete(); m_reset = 1'b1; m_run = 1'b0;
      m_sym = 8'h00; m_drops = 16'd0; m_syms = 32'd0;
      return;
    end
    if (m_run) m_syms = m_syms + 32'd1;
    if (m_mode == M_STREAM && pv && !rdy && m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
    m_run = 1'b0;
    if (fs) begin
      m_q.delete(); m_mode = M_FLUSH; m_left = RC; m_drops = 16'd0; m_syms = 32'd0;
    end else begin
      if ((m_mode == M_STREAM || m_mode == M_DRAIN) && m_q.size() > 0) begin
        m_sym = m_q.pop_front();
        m_run = 1'b1;
      end
      if (pv && rdy) m_q.push_back(pb);
      case (m_mode)
        M_FLUSH: begin
          m_left--;
          if (m_left == 0) m_mode = M_STREAM;
        end
        M_STREAM: if (fe) m_mode = M_DRAIN;
        M_DRAIN:  if (m_q.size() == 0) m_mode = M_IDLE;
        default: ;
      endcase
    end
    m_reset = (m_mode == M_FLUSH);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample 1ns later.
  task automatic step(input logic r, input logic fs, input logic fe,
                      input logic pv, input logic [7:0] pb);
    reset = r; frame_start = fs; frame_end = fe; prop_valid = pv; prop_bits = pb;
    @(posedge clk);
    model_step(r, fs, fe, pv, pb);
    #1;
  endtask

  task automatic go_stream();
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < RC; i++) step(0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 8'h00);
    step(1, 1, 1, 1, 8'hFF);
    total++; if (mon_reset !== 1'b1) begin bad++; $display("FAIL reset_mon_reset: got %b want 1", mon_reset); end
    total++; if (mon_run !== 1'b0) begin bad++; $display("FAIL reset_mon_run: got %b want 0", mon_run); end
    total++; if (mon_symbol !== 8'h00) begin bad++; $display("FAIL reset_symbol: got %h want 00", mon_symbol); end
    total++; if (prop_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_ready_busy: got %b%b want 00", prop_ready, busy); end
    total++; if (drop_count !== 16'd0 || symbol_count !== 32'd0) begin bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", drop_count, symbol_count); end
    step(0, 0, 1, 1, 8'h11);
    total++; if (mon_reset !== 1'b0) begin bad++; $display("FAIL reset_release: got mon_reset=%b want 0", mon_reset); end
    total++; if (busy !== 1'b0 || prop_ready !== 1'b0) begin bad++; $display("FAIL idle_frame_end: got busy=%b ready=%b want 0 0", busy, prop_ready); end
    $display("test_reset done");
  endtask

  task automatic test_frame_start();
    step(0, 1, 0, 1, 8'h33);
    total++; if (mon_reset !== 1'b1 || busy !== 1'b1 || prop_ready !== 1'b0) begin bad++; $display("FAIL flush_c1: got rst=%b busy=%b rdy=%b want 1 1 0", mon_reset, busy, prop_ready); end
    step(0, 0, 0, 1, 8'h34);
    total++; if (mon_reset !== 1'b1 || prop_ready !== 1'b0 || mon_run !== 1'b0) begin bad++; $display("FAIL flush_c2: got rst=%b rdy=%b run=%b want 1 0 0", mon_reset, prop_ready, mon_run); end
    step(0, 0, 0, 0, 8'h00);
    total++; if (mon_reset !== 1'b0 || prop_ready !== 1'b1) begin bad++; $display("FAIL stream_c3: got rst=%b rdy=%b want 0 1", mon_reset, prop_ready); end
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    total++; if (mon_run !== 1'b0 || symbol_count !== 32'd0) begin bad++; $display("FAIL flush_words_ignored: got run=%b count=%0d want 0 0", mon_run, symbol_count); end
    $display("test_frame_start done");
  endtask

  task automatic test_flush_restart();
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    total++; if (mon_reset !== 1'b1) begin bad++; $display("FAIL restart_c1: got %b want 1", mon_reset); end
    step(0, 0, 0, 0, 8'h00);
    total++; if (mon_reset !== 1'b1 || prop_ready !== 1'b0) begin bad++; $display("FAIL restart_c2: got rst=%b rdy=%b want 1 0", mon_reset, prop_ready); end
    step(0, 0, 0, 0, 8'h00);
    total++; if (mon_reset !== 1'b0 || prop_ready !== 1'b1) begin bad++; $display("FAIL restart_c3: got rst=%b rdy=%b want 0 1", mon_reset, prop_ready); end
    $display("test_flush_restart done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] data [3];
    data[0] = 8'h20; data[1] = 8'hA5; data[2] = 8'h7F;
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, k < 3, (k < 3) ? data[k] : 8'h00);
      if (k >= 1 && k <= 3) begin
        total++; if (mon_run !== 1'b1 || mon_symbol !== data[k-1]) begin bad++; $display("FAIL b2b_sym%0d: got run=%b sym=%h want 1 %h", k, mon_run, mon_symbol, data[k-1]); end
      end else begin
        total++; if (mon_run !== 1'b0) begin bad++; $display("FAIL b2b_idle%0d: got run=%b want 0", k, mon_run); end
      end
    end
    total++; if (symbol_count !== 32'd3 || mon_symbol !== 8'h7F) begin bad++; $display("FAIL b2b_count: got %0d sym=%h want 3 7f", symbol_count, mon_symbol); end
    $display("test_back_to_back done");
  endtask

  task automatic test_fill();
    for (int k = 0; k < 14; k++) begin
      step(0, 0, 0, k < 10, 8'(k * 17 + 3));
      total++; if (prop_ready !== m_ready() || mon_run !== m_run || mon_symbol !== m_sym || drop_count !== m_drops) begin
        bad++; $display("FAIL fill_%0d: got rdy=%b run=%b sym=%h drop=%0d want %b %b %h %0d", k, prop_ready, mon_run, mon_symbol, drop_count, m_ready(), m_run, m_sym, m_drops);
      end
    end
    $display("test_fill done");
  endtask

  task automatic test_frame_end();
    bit done;
    go_stream();
    for (int k = 0; k < 4; k++) step(0, 0, k == 3, 1, 8'(8'hC0 + k));
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      total++; if (mon_run !== m_run || mon_symbol !== m_sym || busy !== (m_mode != M_IDLE)) begin
        bad++; $display("FAIL drain_%0d: got run=%b sym=%h busy=%b want %b %h %b", k, mon_run, mon_symbol, busy, m_run, m_sym, m_mode != M_IDLE);
      end
      if (busy === 1'b0) done = 1;
      else step(0, 0, 0, 1, 8'hEE);
    end
    total++; if (!done) begin bad++; $display("FAIL drain_timeout: got busy=%b want 0", busy); end
    step(0, 0, 0, 0, 8'h00);
    total++; if (symbol_count !== 32'd4 || busy !== 1'b0) begin bad++; $display("FAIL drain_count: got %0d busy=%b want 4 0", symbol_count, busy); end
    $display("test_frame_end done");
  endtask

  task automatic test_abort();
    go_stream();
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 8'(8'h50 + k));
    step(0, 1, 0, 1, 8'h99);
    total++; if (mon_run !== 1'b0 || mon_reset !== 1'b1 || symbol_count !== 32'd0) begin bad++; $display("FAIL abort_c1: got run=%b rst=%b cnt=%0d want 0 1 0", mon_run, mon_reset, symbol_count); end
    step(0, 0, 0, 0, 8'h00);
    total++; if (mon_run !== 1'b0 || mon_reset !== 1'b1) begin bad++; $display("FAIL abort_c2: got run=%b rst=%b want 0 1", mon_run, mon_reset); end
    step(0, 0, 0, 0, 8'h00);
    total++; if (mon_run !== 1'b0 || mon_reset !== 1'b0 || symbol_count !== 32'd0) begin bad++; $display("FAIL abort_c3: got run=%b rst=%b cnt=%0d want 0 0 0", mon_run, mon_reset, symbol_count); end
    $display("test_abort done");
  endtask

  task automatic test_reset_in_drain();
    go_stream();
    step(0, 0, 0, 1, 8'h01);
    step(0, 0, 0, 1, 8'h02);
    step(0, 0, 1, 1, 8'h03);
    total++; if (busy !== 1'b1 || prop_ready !== 1'b0) begin bad++; $display("FAIL drain_entry: got busy=%b rdy=%b want 1 0", busy, prop_ready); end
    step(1, 1, 0, 1, 8'h04);
    total++; if (mon_reset !== 1'b1 || mon_run !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL drain_reset: got rst=%b run=%b busy=%b want 1 0 0", mon_reset, mon_run, busy); end
    total++; if (drop_count !== 16'd0 || symbol_count !== 32'd0 || mon_symbol !== 8'h00) begin bad++; $display("FAIL drain_reset_cnt: got %0d/%0d sym=%h want 0/0 00", drop_count, symbol_count, mon_symbol); end
    step(0, 0, 0, 0, 8'h00);
    total++; if (mon_reset !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL drain_reset_release: got rst=%b busy=%b want 0 0", mon_reset, busy); end
    $display("test_reset_in_drain done");
  endtask

  task automatic test_random();
    logic r, fs, fe, pv;
    for (int k = 0; k < 600; k++) begin
      r  = ($urandom_range(0, 249) == 0);
      fs = ($urandom_range(0, 39) == 0);
      fe = ($urandom_range(0, 14) == 0);
      pv = ($urandom_range(0, 3) != 0);
      step(r, fs, fe, pv, 8'($urandom));
      total++; if (mon_reset !== m_reset || mon_run !== m_run || mon_symbol !== m_sym || prop_ready !== m_ready() ||
                   busy !== (m_mode != M_IDLE) || drop_count !== m_drops || symbol_count !== m_syms) begin
        bad++; $display("FAIL rand_%0d: got rst=%b run=%b sym=%h rdy=%b busy=%b drop=%0d cnt=%0d want %b %b %h %b %b %0d %0d",
                        k, mon_reset, mon_run, mon_symbol, prop_ready, busy, drop_count, symbol_count,
                        m_reset, m_run, m_sym, m_ready(), m_mode != M_IDLE, m_drops, m_syms);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_frame_start();
    test_flush_restart();
    test_back_to_back();
    test_fill();
    test_frame_end();
    test_abort();
    test_reset_in_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
